// File: rtl/ddr_wr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_wr_pkg
//  Description : Shared types, counter widths and parameter-legality helpers
//                for the DDR DQS write-path controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ddr_wr_pkg;

    // Latency counter must hold WR_LAT-1 for WR_LAT up to 15.
    localparam int LAT_W  = 4;
    // Beat counter must hold BC-1 for BC up to 4.
    localparam int BEAT_W = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        PRE   = 3'd2,
        BURST = 3'd3,
        POST  = 3'd4
    } wr_state_e;

    // Burst length must be an even number of beats from 2 to 8.
    function automatic bit burst_len_legal(input int bl);
        return (bl >= 2) && (bl <= 8) && ((bl % 2) == 0);
    endfunction

    // Write latency must fit the latency counter and be at least one cycle.
    function automatic bit wr_lat_legal(input int lat);
        return (lat >= 1) && (lat <= 15);
    endfunction

    // At least one byte lane is required.
    function automatic bit num_dqs_legal(input int n);
        return n >= 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_wr_lat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_wr_lat_cnt
//  Description : Loadable down-counter with zero flag. Load has priority over
//                decrement; decrement saturates at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_wr_lat_cnt
    import ddr_wr_pkg::*;
#(
    parameter int WIDTH = LAT_W
) (
    input  logic             ck_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins, otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/ddr_dqs_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_dqs_write_ctrl
//  Description : Write-direction DQS/DQ controller. Turns accepted write
//                commands into cycle-aligned DQ/DQS tristate controls with
//                preamble and half-cycle postamble, and pulls burst data from
//                a show-ahead write FIFO. Outputs feed CK90 ODDR cells.
//                Optional data-mask path enabled by defining DDR_WR_DM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_dqs_write_ctrl
    import ddr_wr_pkg::*;
#(
    parameter int NUM_DQS   = 1,
    parameter int BURST_LEN = 4,
    parameter int WR_LAT    = 1
) (
    input  logic                 ck_i,
    input  logic                 rst_i,
    input  logic                 wr_req_i,
    output logic                 wr_ack_o,
    output logic                 data_req_o,
    input  logic [NUM_DQS*8-1:0] wr_data_rise_i,
    input  logic [NUM_DQS*8-1:0] wr_data_fall_i,
    output logic [NUM_DQS*8-1:0] dq_rise_o,
    output logic [NUM_DQS*8-1:0] dq_fall_o,
    output logic                 dqtri_o,
    output logic                 dqstri_pos_o,
    output logic                 dqstri_neg_o,
`ifdef DDR_WR_DM_EN
    input  logic [NUM_DQS-1:0]   wr_dm_rise_i,
    input  logic [NUM_DQS-1:0]   wr_dm_fall_i,
    output logic [NUM_DQS-1:0]   dm_rise_o,
    output logic [NUM_DQS-1:0]   dm_fall_o,
`endif
    output logic                 busy_o
);

    localparam int                DQ_W      = NUM_DQS * 8;
    localparam int                BC        = BURST_LEN / 2;
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(WR_LAT - 1);
    localparam logic [BEAT_W-1:0] BEAT_LOAD = BEAT_W'(BC - 1);

    // Elaboration-time parameter checks.
    if (!burst_len_legal(BURST_LEN)) begin : g_bad_burst_len
        $error("ddr_dqs_write_ctrl: BURST_LEN must be even and 2..8");
    end
    if (!wr_lat_legal(WR_LAT)) begin : g_bad_wr_lat
        $error("ddr_dqs_write_ctrl: WR_LAT must be 1..15");
    end
    if (!num_dqs_legal(NUM_DQS)) begin : g_bad_num_dqs
        $error("ddr_dqs_write_ctrl: NUM_DQS must be at least 1");
    end

    wr_state_e        state_q;
    wr_state_e        state_d;

    logic             lat_load;
    logic             lat_dec;
    logic [LAT_W-1:0] lat_cnt;
    logic             lat_zero;

    logic              beat_load;
    logic              beat_dec;
    logic [BEAT_W-1:0] beat_cnt;
    logic              beat_zero;
    logic              w_beat_cnt_unused;

    logic             w_accept;

    logic             dqtri_q,      dqtri_d;
    logic             dqstri_pos_q, dqstri_pos_d;
    logic             dqstri_neg_q, dqstri_neg_d;
    logic [DQ_W-1:0]  dq_rise_q,    dq_rise_d;
    logic [DQ_W-1:0]  dq_fall_q,    dq_fall_d;

    // Command handshake and FIFO pull are blanked while reset is applied so
    // nothing is accepted or popped in a reset cycle.
    assign wr_ack_o   = (state_q == IDLE) && !rst_i;
    assign w_accept   = wr_req_i && wr_ack_o;
    assign data_req_o = ((state_q == PRE) || ((state_q == BURST) && !beat_zero)) && !rst_i;
    assign busy_o     = (state_q != IDLE);

    // The beat count value itself is not needed, only its zero flag.
    assign w_beat_cnt_unused = ^beat_cnt;

    ddr_wr_lat_cnt #(
        .WIDTH      (LAT_W)
    ) u_lat_cnt (
        .ck_i       (ck_i),
        .rst_i      (rst_i),
        .load_i     (lat_load),
        .load_val_i (LAT_LOAD),
        .dec_i      (lat_dec),
        .cnt_o      (lat_cnt),
        .zero_o     (lat_zero)
    );

    ddr_wr_lat_cnt #(
        .WIDTH      (BEAT_W)
    ) u_beat_cnt (
        .ck_i       (ck_i),
        .rst_i      (rst_i),
        .load_i     (beat_load),
        .load_val_i (BEAT_LOAD),
        .dec_i      (beat_dec),
        .cnt_o      (beat_cnt),
        .zero_o     (beat_zero)
    );

    // Next-state decode and the drive controls the next state implies.
    always_comb begin
        state_d   = state_q;
        lat_load  = 1'b0;
        lat_dec   = 1'b0;
        beat_load = 1'b0;
        beat_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    lat_load = 1'b1;
                    state_d  = (WR_LAT == 1) ? PRE : WAIT;
                end
            end
            WAIT: begin
                lat_dec = 1'b1;
                // Zero only reachable if the counter was disturbed; leave anyway.
                if ((lat_cnt == LAT_W'(1)) || lat_zero) begin
                    state_d = PRE;
                end
            end
            PRE: begin
                beat_load = 1'b1;
                state_d   = BURST;
            end
            BURST: begin
                beat_dec = 1'b1;
                if (beat_zero) begin
                    state_d = POST;
                end
            end
            POST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        dqtri_d      = (state_d != BURST);
        dqstri_pos_d = !(state_d inside {PRE, BURST, POST});
        dqstri_neg_d = !(state_d inside {PRE, BURST});
        dq_rise_d    = data_req_o ? wr_data_rise_i : dq_rise_q;
        dq_fall_d    = data_req_o ? wr_data_fall_i : dq_fall_q;
    end

    // State register.
    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered drive controls and data, aligned with the state they describe.
    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            dqtri_q      <= 1'b1;
            dqstri_pos_q <= 1'b1;
            dqstri_neg_q <= 1'b1;
            dq_rise_q    <= '0;
            dq_fall_q    <= '0;
        end else begin
            dqtri_q      <= dqtri_d;
            dqstri_pos_q <= dqstri_pos_d;
            dqstri_neg_q <= dqstri_neg_d;
            dq_rise_q    <= dq_rise_d;
            dq_fall_q    <= dq_fall_d;
        end
    end

    assign dqtri_o      = dqtri_q;
    assign dqstri_pos_o = dqstri_pos_q;
    assign dqstri_neg_o = dqstri_neg_q;
    assign dq_rise_o    = dq_rise_q;
    assign dq_fall_o    = dq_fall_q;

`ifdef DDR_WR_DM_EN
    logic [NUM_DQS-1:0] dm_rise_q, dm_rise_d;
    logic [NUM_DQS-1:0] dm_fall_q, dm_fall_d;

    // Mask bits travel with their data beat and hold between bursts.
    always_comb begin
        dm_rise_d = data_req_o ? wr_dm_rise_i : dm_rise_q;
        dm_fall_d = data_req_o ? wr_dm_fall_i : dm_fall_q;
    end

    // Mask registers, same timing as the DQ registers.
    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            dm_rise_q <= '0;
            dm_fall_q <= '0;
        end else begin
            dm_rise_q <= dm_rise_d;
            dm_fall_q <= dm_fall_d;
        end
    end

    assign dm_rise_o = dm_rise_q;
    assign dm_fall_o = dm_fall_q;
`else
    // No mask path: every written byte is stored.
`endif

endmodule
`default_nettype wire

// File: tb/tb_ddr_dqs_write_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_dqs_write_ctrl
//  Description : Self-checking bench for ddr_dqs_write_ctrl. Two instances
//                (WR_LAT=3/BURST_LEN=4 and WR_LAT=1/BURST_LEN=8) are compared
//                every cycle against a timeline model of each write command.
//                Mask ports are exercised when DDR_WR_DM_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_dqs_write_ctrl;

    localparam int A_LAT = 3;
    localparam int A_BL  = 4;
    localparam int A_BC  = A_BL / 2;
    localparam int B_LAT = 1;
    localparam int B_BL  = 8;
    localparam int B_BC  = B_BL / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        a_req, a_ack, a_dreq, a_dqtri, a_pos, a_neg, a_busy;
    logic [7:0]  a_dr, a_df, a_qr, a_qf;
    logic        b_req, b_ack, b_dreq, b_dqtri, b_pos, b_neg, b_busy;
    logic [15:0] b_dr, b_df, b_qr, b_qf;
`ifdef DDR_WR_DM_EN
    logic        a_mr, a_mf, a_omr, a_omf;
    logic [1:0]  b_mr, b_mf, b_omr, b_omf;
    logic [1:0]  a_em, b_em_r, b_em_f;
`endif

    ddr_dqs_write_ctrl #(.NUM_DQS(1), .BURST_LEN(A_BL), .WR_LAT(A_LAT)) u_dut_a (
        .ck_i           (clk),
        .rst_i          (rst),
        .wr_req_i       (a_req),
        .wr_ack_o       (a_ack),
        .data_req_o     (a_dreq),
        .wr_data_rise_i (a_dr),
        .wr_data_fall_i (a_df),
        .dq_rise_o      (a_qr),
        .dq_fall_o      (a_qf),
        .dqtri_o        (a_dqtri),
        .dqstri_pos_o   (a_pos),
        .dqstri_neg_o   (a_neg),
`ifdef DDR_WR_DM_EN
        .wr_dm_rise_i   (a_mr),
        .wr_dm_fall_i   (a_mf),
        .dm_rise_o      (a_omr),
        .dm_fall_o      (a_omf),
`endif
        .busy_o         (a_busy)
    );

    ddr_dqs_write_ctrl #(.NUM_DQS(2), .BURST_LEN(B_BL), .WR_LAT(B_LAT)) u_dut_b (
        .ck_i           (clk),
        .rst_i          (rst),
        .wr_req_i       (b_req),
        .wr_ack_o       (b_ack),
        .data_req_o     (b_dreq),
        .wr_data_rise_i (b_dr),
        .wr_data_fall_i (b_df),
        .dq_rise_o      (b_qr),
        .dq_fall_o      (b_qf),
        .dqtri_o        (b_dqtri),
        .dqstri_pos_o   (b_pos),
        .dqstri_neg_o   (b_neg),
`ifdef DDR_WR_DM_EN
        .wr_dm_rise_i   (b_mr),
        .wr_dm_fall_i   (b_mf),
        .dm_rise_o      (b_omr),
        .dm_fall_o      (b_omf),
`endif
        .busy_o         (b_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected controls for a command accepted 'rel' cycles ago:
    // preamble at lat, burst lat+1..lat+bc, postamble lat+bc+1,
    // FIFO pulls on lat..lat+bc-1. Returns {busy, pull, dqtri, pos, neg}.
    function automatic logic [4:0] exp_ctl(input int lat, input int bc, input bit act, input int rel);
        bit busy, pull, drv_dq, drv_pos, drv_neg;
        busy    = act && (rel >= 1)   && (rel <= lat + bc + 1);
        pull    = act && (rel >= lat) && (rel <= lat + bc - 1);
        drv_dq  = act && (rel >= lat + 1) && (rel <= lat + bc);
        drv_pos = act && (rel >= lat) && (rel <= lat + bc + 1);
        drv_neg = act && (rel >= lat) && (rel <= lat + bc);
        return {busy, pull, !drv_dq, !drv_pos, !drv_neg};
    endfunction

    task automatic chk_lane(input string p, input logic [4:0] e, input bit r,
                            input logic g_busy, input logic g_ack, input logic g_dreq,
                            input logic g_dqtri, input logic g_pos, input logic g_neg,
                            input logic [15:0] g_qr, input logic [15:0] g_qf,
                            input logic [15:0] e_qr, input logic [15:0] e_qf);
        chk({p, "_busy"},       32'(g_busy),  32'(e[4]));
        chk({p, "_wr_ack"},     32'(g_ack),   32'(!e[4] && !r));
        chk({p, "_data_req"},   32'(g_dreq),  32'(e[3] && !r));
        chk({p, "_dqtri"},      32'(g_dqtri), 32'(e[2]));
        chk({p, "_dqstri_pos"}, 32'(g_pos),   32'(e[1]));
        chk({p, "_dqstri_neg"}, 32'(g_neg),   32'(e[0]));
        chk({p, "_dq_rise"},    32'(g_qr),    32'(e_qr));
        chk({p, "_dq_fall"},    32'(g_qf),    32'(e_qf));
    endtask

    // Reference model state.
    int          cyc = 0;
    bit          a_act = 1'b0, b_act = 1'b0;
    int          a_t0 = 0, b_t0 = 0;
    logic [15:0] a_er = '0, a_ef = '0, b_er = '0, b_ef = '0;
    int          a_pulls_total = 0;
    int          a_obs_pulls = 0;
    bit          rec_acc = 1'b0;
    int          a_acc_q[$];
    int          b_acc_q[$];

    // One clock cycle: drive inputs, check at the falling edge, advance model.
    task automatic run_cycle(input bit r, input bit ra, input bit rb);
        logic [4:0] ea, eb;
        bit a_acc, b_acc;
        rst   = r;
        a_req = ra;
        b_req = rb;
        if (a_pulls_total == 0) begin
            a_dr = 8'hA5;
            a_df = 8'h5A;
        end else if (a_pulls_total == 1) begin
            a_dr = 8'h3C;
            a_df = 8'hC3;
        end else begin
            a_dr = 8'($urandom);
            a_df = 8'($urandom);
        end
        b_dr = 16'($urandom);
        b_df = 16'($urandom);
`ifdef DDR_WR_DM_EN
        // First burst beat 0 masked, beat 1 unmasked; random afterwards.
        a_mr = (a_pulls_total == 0) ? 1'b1 : ((a_pulls_total == 1) ? 1'b0 : 1'($urandom));
        a_mf = (a_pulls_total < 2) ? 1'b0 : 1'($urandom);
        b_mr = 2'($urandom);
        b_mf = 2'($urandom);
`endif
        @(negedge clk);
        ea = exp_ctl(A_LAT, A_BC, a_act, cyc - a_t0);
        eb = exp_ctl(B_LAT, B_BC, b_act, cyc - b_t0);
        chk_lane("a", ea, r, a_busy, a_ack, a_dreq, a_dqtri, a_pos, a_neg,
                 16'(a_qr), 16'(a_qf), a_er, a_ef);
        chk_lane("b", eb, r, b_busy, b_ack, b_dreq, b_dqtri, b_pos, b_neg,
                 b_qr, b_qf, b_er, b_ef);
`ifdef DDR_WR_DM_EN
        chk("a_dm_rise", 32'(a_omr), 32'(a_em[0]));
        chk("a_dm_fall", 32'(a_omf), 32'(a_em[1]));
        chk("b_dm_rise", 32'(b_omr), 32'(b_em_r));
        chk("b_dm_fall", 32'(b_omf), 32'(b_em_f));
`endif
        a_acc = ra && !ea[4] && !r;
        b_acc = rb && !eb[4] && !r;
        if (a_req && a_ack) begin
            a_obs_pulls = 0;
            if (rec_acc) a_acc_q.push_back(cyc);
        end
        if (rec_acc && b_req && b_ack) b_acc_q.push_back(cyc);
        if (a_dreq === 1'b1) a_obs_pulls++;
        @(posedge clk);
        if (r) begin
            a_act = 1'b0;  b_act = 1'b0;
            a_er = '0;     a_ef = '0;
            b_er = '0;     b_ef = '0;
`ifdef DDR_WR_DM_EN
            a_em = '0;     b_em_r = '0;   b_em_f = '0;
`endif
        end else begin
            if (ea[3]) begin
                a_er = 16'(a_dr);
                a_ef = 16'(a_df);
                a_pulls_total++;
`ifdef DDR_WR_DM_EN
                a_em = {a_mf, a_mr};
`endif
            end
            if (eb[3]) begin
                b_er = b_dr;
                b_ef = b_df;
`ifdef DDR_WR_DM_EN
                b_em_r = b_mr;
                b_em_f = b_mf;
`endif
            end
            if (a_acc) begin a_act = 1'b1; a_t0 = cyc; end
            if (b_acc) begin b_act = 1'b1; b_t0 = cyc; end
        end
        cyc++;
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit hit;
        rst   = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        a_dr = '0; a_df = '0; b_dr = '0; b_df = '0;
`ifdef DDR_WR_DM_EN
        a_mr = 1'b0; a_mf = 1'b0; b_mr = '0; b_mf = '0;
        a_em = '0; b_em_r = '0; b_em_f = '0;
`endif
        @(posedge clk);
        #1;

        // Reset held for three cycles in total, then idle.
        run_cycle(1'b1, 1'b1, 1'b1);
        run_cycle(1'b1, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0);
        run_cycle(1'b0, 1'b0, 1'b0);

        // Write request held high continuously.
        rec_acc = 1'b1;
        for (int i = 0; i < 30; i++) run_cycle(1'b0, 1'b1, 1'b1);
        rec_acc = 1'b0;
        chk("a_accepts_seen", 32'(a_acc_q.size() >= 2), 32'd1);
        chk("b_accepts_seen", 32'(b_acc_q.size() >= 2), 32'd1);
        if (a_acc_q.size() >= 2) chk("a_accept_gap", 32'(a_acc_q[1] - a_acc_q[0]), 32'(A_LAT + A_BC + 2));
        if (b_acc_q.size() >= 2) chk("b_accept_gap", 32'(b_acc_q[1] - b_acc_q[0]), 32'(B_LAT + B_BC + 2));

        // Reset in the second burst cycle of instance a.
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (a_act && ((cyc - a_t0) == A_LAT + 2)) begin
                hit = 1'b1;
                break;
            end
            run_cycle(1'b0, 1'b1, 1'b1);
        end
        chk("a_reach_burst2", 32'(hit), 32'd1);
        if (hit) begin
            run_cycle(1'b1, 1'b1, 1'b1);
            run_cycle(1'b0, 1'b0, 1'b0);
            chk("a_pulls_before_reset", 32'(a_obs_pulls), 32'd2);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            run_cycle($urandom_range(0, 99) < 3,
                      $urandom_range(0, 9) < 6,
                      $urandom_range(0, 9) < 6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr_dqs_write_ctrl.md
Name: ddr_dqs_write_ctrl

Overview:
- Write-direction companion to the DQS read-capture block.
- Converts accepted write commands into cycle-aligned DQS/DQ drive controls and preamble/postamble framing.
- Pulls burst data from the controller's write FIFO.
- Outputs feed ODDRXA/BB write-path cells clocked by CK90. DQSTRI_POS/DQSTRI_NEG match the tristate inputs of the read-capture block.

Parameters:
- NUM_DQS, 1, byte lanes; DQ width is NUM_DQS*8.
- BURST_LEN, 4, DDR beats per write burst; must be even and 2..8; cycles per burst BC=BURST_LEN/2.
- WR_LAT, 1, CK cycles from command acceptance to the preamble cycle; 1..15.

Ports:
- CK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- WR_REQ  in  1  write command valid.
- WR_ACK  out  1  command accepted when WR_REQ&WR_ACK.
- DATA_REQ  out  1  pull strobe; WR_DATA_* must be valid in the same cycle (show-ahead FIFO).
- WR_DATA_RISE  in  NUM_DQS*8  even beat.
- WR_DATA_FALL  in  NUM_DQS*8  odd beat.
- DQ_RISE  out  NUM_DQS*8  registered to ODDR DA.
- DQ_FALL  out  NUM_DQS*8  registered to ODDR DB.
- DQTRI  out  1  1=DQ tristated.
- DQSTRI_POS  out  1  DQS tristate, first half-cycle.
- DQSTRI_NEG  out  1  DQS tristate, second half-cycle.
- BUSY  out  1  high whenever state!=IDLE.

Behaviour:
- Reset values: WR_ACK=0, DATA_REQ=0, DQ_RISE/FALL=0, DQTRI=1, DQSTRI_POS=1, DQSTRI_NEG=1, BUSY=0, state=IDLE, counters=0.
- FSM states and transitions:
  - IDLE: WR_ACK=1. On accept, load lat_cnt=WR_LAT-1. Go to PRE if WR_LAT==1, else WAIT.
  - WAIT: decrement lat_cnt; when lat_cnt==1, go to PRE. WR_ACK=0.
  - PRE: 1 cycle. DQSTRI_POS=DQSTRI_NEG=0 (DQS driven low = preamble). DQTRI=1. DATA_REQ=1. Load beat_cnt=BC-1. Go to BURST.
  - BURST: BC cycles. DQSTRI_*=0, DQTRI=0. DQ_RISE/DQ_FALL hold data captured on the previous DATA_REQ. DATA_REQ=1 while beat_cnt!=0. Decrement beat_cnt; at 0 go to POST.
  - POST: 1 cycle. DQSTRI_POS=0, DQSTRI_NEG=1 (half-cycle postamble). DQTRI=1. Then go to IDLE.
- Tristate and data outputs are registered from next-state decode, so they are aligned to the state they describe.
- Exactly BC DATA_REQ pulses per command, contiguous, starting in PRE.
- Accept cycle is t. Preamble is at t+WR_LAT, burst at t+WR_LAT+1..t+WR_LAT+BC, postamble at t+WR_LAT+BC+1. Next accept is possible at t+WR_LAT+BC+2.
- WR_REQ outside IDLE is ignored (WR_ACK=0). There is no queuing.
- DQ_RISE/DQ_FALL hold their last value when DQTRI=1. They are never updated without DATA_REQ.
- RST asserted mid-burst: at the next edge return to reset values. No further DATA_REQ. The partially transferred burst is discarded and the FIFO is not rewound.
- WR_REQ high in the same cycle RST is high: ignored.

Optional Feature:
- DDR_WR_DM_EN defined:
  - Adds inputs WR_DM_RISE/WR_DM_FALL [NUM_DQS-1:0], pulled with DATA_REQ.
  - Adds outputs DM_RISE/DM_FALL, registered like DQ. Reset value 0; hold when idle.
- Undefined: these ports are absent; masking is not supported.

Decomposition:
- Package ddr_wr_pkg holds:
  - state enum (IDLE, WAIT, PRE, BURST, POST);
  - LAT_W=4, BEAT_W=2;
  - parameter-legality checks.
- One sub-module: ddr_wr_lat_cnt, a loadable down-counter with zero flag, instantiated twice (latency and beat).

Test Plan:
1. Reset then idle: RST high 3 cycles → DQTRI=1, DQSTRI_POS/NEG=1, WR_ACK=1 the first cycle after release, DQ=0.
2. Single write, WR_LAT=3, BURST_LEN=4, data 0xA5/0x5A then 0x3C/0xC3 → PRE at t+3, DQ valid at t+4 and t+5, POST at t+6 with POS=0/NEG=1, exactly 2 DATA_REQ.
3. WR_LAT=1, BURST_LEN=8 → PRE at t+1, 4 burst cycles, BUSY high for 6 cycles, WR_ACK back at t+7.
4. WR_REQ held high continuously → second accept exactly BC+WR_LAT+2 cycles after the first, no overlap of DQTRI=0 windows.
5. RST asserted in the 2nd BURST cycle → next cycle all tristates=1, DATA_REQ=0, BUSY=0; total DATA_REQ count is 2.
6. DDR_WR_DM_EN with WR_DM_RISE=1 on beat 0 → DM_RISE=1 aligned with the first DQ_RISE cycle, 0 elsewhere.
